iir_bandpass_cascade: RTL and testbench

IIR_BANDPASS_CASCADE -- requirements
Module: iir_bandpass_cascade

---
 rtl/iir_bandpass_cascade.sv | 161 ++++++++++++++++
 tb/tb_iir_bandpass_cascade.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_bandpass_cascade.sv
// Time-multiplexed cascade of direct-form-I biquads sharing one multiplier.
// Each section takes five MAC cycles plus one rounding cycle per sample.
module iir_bandpass_cascade #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC   = 16,
  parameter int N_SECT = 2,
  parameter int N_CH   = 1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW    = $clog2(5 * N_SECT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              clear,
  output logic              busy,
  output logic              ovf
);
  localparam int ACC_W  = DATA_W + COEF_W + 4;
  localparam int N_COEF = 5 * N_SECT;
  localparam int N_DL   = N_SECT * N_CH;
  localparam int SW     = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] half;
    half = '0;
    half[FRAC-1] = 1'b1;
    return (a + half) >>> FRAC;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [SW-1:0] s_q, s_d;
  logic [CH_W-1:0] ch_q, ch_d, out_ch_q, out_ch_d;
  logic signed [DATA_W-1:0] x_q, x_d, out_data_q, out_data_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic signed [COEF_W-1:0] coef_q [N_COEF];
  logic signed [COEF_W-1:0] coef_d [N_COEF];
  logic signed [DATA_W-1:0] x1_q [N_DL];
  logic signed [DATA_W-1:0] x1_d [N_DL];
  logic signed [DATA_W-1:0] x2_q [N_DL];
  logic signed [DATA_W-1:0] x2_d [N_DL];
  logic signed [DATA_W-1:0] y1_q [N_DL];
  logic signed [DATA_W-1:0] y1_d [N_DL];
  logic signed [DATA_W-1:0] y2_q [N_DL];
  logic signed [DATA_W-1:0] y2_d [N_DL];

  int cidx, didx;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [DATA_W-1:0] op_sel, y_sat;
  logic signed [ACC_W-1:0] c_ext, op_ext, prod, y_rnd;

  always_comb begin
    state_d = state_q;  k_d = k_q;  s_d = s_q;  ch_d = ch_q;  x_d = x_q;
    acc_d = acc_q;  out_data_d = out_data_q;  out_ch_d = out_ch_q;  ovf_d = 1'b0;
    coef_d = coef_q;  x1_d = x1_q;  x2_d = x2_q;  y1_d = y1_q;  y2_d = y2_q;

    cidx = int'(s_q) * 5 + int'(k_q);
    didx = int'(s_q) * N_CH + int'(ch_q);
    c_sel = coef_q[cidx];
    case (k_q)
      3'd0:    op_sel = x_q;
      3'd1:    op_sel = x1_q[didx];
      3'd2:    op_sel = x2_q[didx];
      3'd3:    op_sel = y1_q[didx];
      default: op_sel = y2_q[didx];
    endcase
    c_ext  = {{(ACC_W-COEF_W){c_sel[COEF_W-1]}}, c_sel};
    op_ext = {{(ACC_W-DATA_W){op_sel[DATA_W-1]}}, op_sel};
    prod   = c_ext * op_ext;
    y_rnd  = round_shift(acc_q);
    y_sat  = saturate(y_rnd);

    case (state_q)
      IDLE: begin
        if (clear) begin
          for (int i = 0; i < N_DL; i++) begin
            x1_d[i] = '0;  x2_d[i] = '0;  y1_d[i] = '0;  y2_d[i] = '0;
          end
        end else if (in_valid) begin
          x_d = in_data;
          ch_d = (int'(in_ch) < N_CH) ? in_ch : '0;
          s_d = '0;  k_d = '0;  acc_d = '0;
          state_d = MAC;
        end
        if (coef_we && (int'(coef_addr) < N_COEF)) coef_d[int'(coef_addr)] = coef_wdata;
      end
      MAC: begin
        // Feedback taps (k = 3, 4) enter with negative sign.
        acc_d = (k_q >= 3'd3) ? acc_q - prod : acc_q + prod;
        if (k_q == 3'd4) state_d = ROUND;
        else k_d = k_q + 3'd1;
      end
      ROUND: begin
        ovf_d = sat_hit(y_rnd);
        x2_d[didx] = x1_q[didx];  x1_d[didx] = x_q;
        y2_d[didx] = y1_q[didx];  y1_d[didx] = y_sat;
        if (s_q == SW'(N_SECT - 1)) begin
          out_data_d = y_sat;
          out_ch_d = ch_q;
          state_d = OUT;
        end else begin
          s_d = s_q + SW'(1);
          x_d = y_sat;  k_d = '0;  acc_d = '0;
          state_d = MAC;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  k_q <= '0;  s_q <= '0;  ch_q <= '0;  x_q <= '0;  acc_q <= '0;
      out_data_q <= '0;  out_ch_q <= '0;  ovf_q <= 1'b0;
      for (int i = 0; i < N_COEF; i++) coef_q[i] <= (i % 5 == 0) ? UNITY : '0;
      for (int i = 0; i < N_DL; i++) begin
        x1_q[i] <= '0;  x2_q[i] <= '0;  y1_q[i] <= '0;  y2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;  k_q <= k_d;  s_q <= s_d;  ch_q <= ch_d;  x_q <= x_d;  acc_q <= acc_d;
      out_data_q <= out_data_d;  out_ch_q <= out_ch_d;  ovf_q <= ovf_d;
      coef_q <= coef_d;  x1_q <= x1_d;  x2_q <= x2_d;  y1_q <= y1_d;  y2_q <= y2_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !clear;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_iir_bandpass_cascade.sv
// Scoreboard bench for iir_bandpass_cascade (two sections, two channels)
// against an integer-arithmetic reference of the cascaded difference equations.
module tb_iir_bandpass_cascade;
  localparam int DW = 16, CW = 18, FR = 16, NS = 2, NC = 2, P = 10;

  logic clk = 1'b0;
  logic rst, in_valid, coef_we, clear;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, busy, ovf;
  logic signed [DW-1:0] in_data, out_data;
  logic [0:0] in_ch, out_ch;
  logic [3:0] coef_addr;
  logic [CW-1:0] coef_wdata;

  always #(P/2) clk = ~clk;

  iir_bandpass_cascade #(.DATA_W(DW), .COEF_W(CW), .FRAC(FR), .N_SECT(NS), .N_CH(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .clear(clear), .busy(busy), .ovf(ovf));

  typedef struct { int d; int ch; longint t; int ovf; } exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, ovf_seen = 0, ovf_exp = 0;
  bit rnd_bp = 0, hold = 0, prev_valid = 0;
  longint mc [10];
  longint mx1 [NS][NC];
  longint mx2 [NS][NC];
  longint my1 [NS][NC];
  longint my2 [NS][NC];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear_state();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++) begin
        mx1[s][c] = 0; mx2[s][c] = 0; my1[s][c] = 0; my2[s][c] = 0;
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) mc[i] = (i % 5 == 0) ? 65536 : 0;
    model_clear_state();
  endtask

  task automatic model_step(input int xin, input int ch, output int y, output int nov);
    longint x, acc, q;
    x = xin; nov = 0;
    for (int s = 0; s < NS; s++) begin
      acc = mc[5*s]*x + mc[5*s+1]*mx1[s][ch] + mc[5*s+2]*mx2[s][ch]
          - mc[5*s+3]*my1[s][ch] - mc[5*s+4]*my2[s][ch];
      q = (acc + (64'sd1 <<< (FR-1))) >>> FR;
      if (q > 32767) begin q = 32767; nov++; end
      else if (q < -32768) begin q = -32768; nov++; end
      mx2[s][ch] = mx1[s][ch]; mx1[s][ch] = x;
      my2[s][ch] = my1[s][ch]; my1[s][ch] = q;
      x = q;
    end
    y = int'(x);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic send(input int d, input int ch);
    exp_t e;
    int y, nov;
    wait_idle();
    in_valid = 1'b1; in_data = d[DW-1:0]; in_ch = ch[0:0];
    @(posedge clk);
    model_step(d, ch, y, nov);
    ovf_exp += nov;
    e.d = y; e.ch = ch; e.t = $time; e.ovf = ovf_exp;
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    wait_idle();
    coef_we = 1'b1; coef_addr = a[3:0]; coef_wdata = v[CW-1:0];
    @(posedge clk);
    if (a < 10) mc[a] = v;
    #1 coef_we = 1'b0;
  endtask

  task automatic do_clear(input bit with_valid);
    wait_idle();
    clear = 1'b1; in_valid = with_valid; in_data = 16'sd777; in_ch = 1'b0;
    #1 check("ready_low_on_clear", in_ready, 0);
    @(posedge clk);
    model_clear_state();
    #1 clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 3000) begin @(negedge clk); g++; end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor: counts ovf pulses, drives out_ready, pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ovf === 1'b1) ovf_seen++;
      out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : !hold;
      if (out_valid && !prev_valid && exp_q.size() > 0)
        check("latency", $time - exp_q[0].t, 12*P + P/2);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %0d with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_ch", out_ch, e.ch);
          check("ovf_count", ovf_seen, e.ovf);
        end
      end
      prev_valid = out_valid;
    end else prev_valid = 1'b0;
  end

  initial begin
    int g;
    rst = 1'b1; in_valid = 0; in_data = 0; in_ch = 0; coef_we = 0; coef_addr = 0;
    coef_wdata = 0; clear = 0;
    model_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b0;

    // passthrough defaults
    send(1000, 0);
    send(-1234, 1);
    drain();

    // section 0 averaging impulse response
    do_clear(0);
    write_coef(0, 32768); write_coef(1, 32768); write_coef(2, 32768);
    send(1000, 0);
    for (int i = 0; i < 4; i++) send(0, 0);
    drain();

    // gain of ~2 in both sections drives saturation
    do_clear(0);
    write_coef(1, 0); write_coef(2, 0);
    write_coef(0, 131071); write_coef(5, 131071);
    send(32767, 0); send(-32768, 0); send(1000, 1); send(-16000, 1);
    drain();

    // backpressure hold
    hold = 1'b1;
    send(100, 1);
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    check("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", out_valid, 1);
      check("bp_ready_low", in_ready, 0);
      if (exp_q.size() > 0) check("bp_data_hold", out_data, exp_q[0].d);
      @(negedge clk);
    end
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after", in_ready, 1);
    check("bp_valid_drop", out_valid, 0);
    send(5, 0);
    drain();

    // two-channel leaky recursion on section 0
    write_coef(0, 65536); write_coef(5, 65536);
    do_clear(0);
    write_coef(3, -32768);
    for (int i = 0; i < 3; i++) begin
      send((i == 0) ? 1000 : 0, 0);
      send(0, 1);
    end
    drain();
    do_clear(1);
    send(0, 0);
    drain();

    // writes and clear while busy, and out-of-range address, are ignored
    send(300, 0);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = '0; clear = 1'b1;
    @(posedge clk);
    #1 coef_we = 1'b0; clear = 1'b0;
    write_coef(12, 0);
    send(300, 0);
    drain();

    // randomized coefficients, samples, channels and backpressure
    rnd_bp = 1'b1;
    do_clear(0);
    for (int s = 0; s < NS; s++) begin
      write_coef(5*s,   $urandom_range(0, 80000) - 40000);
      write_coef(5*s+1, $urandom_range(0, 80000) - 40000);
      write_coef(5*s+2, $urandom_range(0, 80000) - 40000);
      write_coef(5*s+3, $urandom_range(0, 60000) - 30000);
      write_coef(5*s+4, $urandom_range(0, 30000) - 15000);
    end
    for (int i = 0; i < 40; i++) send($urandom_range(0, 65535) - 32768, $urandom_range(0, 1));
    drain();
    rnd_bp = 1'b0;

    // reset in the middle of MAC
    send(1000, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(1000, 0);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
